// File: rtl/sensor_emu_playback_seq.sv
// Sensor-emulation playback sequencer: loads 64-bit words into two external FWFT FIFOs,
// sequences their resets, and streams one FIFO at a time onto an AXI-Stream master.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no FIFO streaming; AXIS outputs and read enables held low
// PLAY_F0  | streaming F0 to AXIS; a start for F1 is parked as pending
// PLAY_F1  | streaming F1 to AXIS; a start for F0 is parked as pending
module sensor_emu_playback_seq #(
   parameter int unsigned RESET_CYCLES = 16
) (
   input  logic        clk,
   input  logic        resetn,

   input  logic        i_fifo_ctl_f0_reset,
   input  logic        i_fifo_ctl_f1_reset,
   input  logic        i_fifo_ctl_wstrobe,
   input  logic [31:0] i_upper32,
   input  logic [31:0] i_load_f0,
   input  logic        i_load_f0_wstrobe,
   input  logic [31:0] i_load_f1,
   input  logic        i_load_f1_wstrobe,
   input  logic [1:0]  i_start,
   input  logic        i_start_wstrobe,
   input  logic        i_hard_stop_wstrobe,

   output logic        o_f0_rst,
   output logic        o_f0_wen,
   output logic [63:0] o_f0_wdata,
   input  logic        i_f0_full,
   input  logic        i_f0_empty,
   output logic        o_f0_ren,
   input  logic [63:0] i_f0_rdata,

   output logic        o_f1_rst,
   output logic        o_f1_wen,
   output logic [63:0] o_f1_wdata,
   input  logic        i_f1_full,
   input  logic        i_f1_empty,
   output logic        o_f1_ren,
   input  logic [63:0] i_f1_rdata,

   output logic [63:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   output logic        m_axis_tlast,
   input  logic        m_axis_tready,

   output logic        o_fifo_stat_f0_reset,
   output logic        o_fifo_stat_f1_reset,
   output logic [31:0] o_f0_count,
   output logic [31:0] o_f1_count,
   output logic [1:0]  o_active_fifo,
   output logic        o_load_drop
);

   localparam int unsigned    RCW     = $clog2(2 * RESET_CYCLES + 1);
   localparam logic [RCW-1:0] RC_FULL = RCW'(2 * RESET_CYCLES);
   localparam logic [RCW-1:0] RC_HALF = RCW'(RESET_CYCLES);

   // Encodings double as the o_active_fifo / i_start values.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PLAY_F0 = 2'd1,
      PLAY_F1 = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [1:0]      pend, pend_nxt;

   logic [1:0]      rst_req, ld_stb, full, empty, busy, avail, ld_ok, ren, wen_q;
   logic [31:0]     ld_lo   [2];
   logic [63:0]     rdata   [2];
   logic [63:0]     wdata_q [2];
   logic [31:0]     cnt     [2];
   logic [RCW-1:0]  rst_cnt [2];
   logic            drop_q;
   logic            cur;
   logic            start_ok;
   logic            last_hs;

   assign rst_req  = {2{i_fifo_ctl_wstrobe}} & {i_fifo_ctl_f1_reset, i_fifo_ctl_f0_reset};
   assign ld_stb   = {i_load_f1_wstrobe, i_load_f0_wstrobe};
   assign full     = {i_f1_full, i_f0_full};
   assign empty    = {i_f1_empty, i_f0_empty};
   assign ld_lo[0] = i_load_f0;
   assign ld_lo[1] = i_load_f1;
   assign rdata[0] = i_f0_rdata;
   assign rdata[1] = i_f1_rdata;

   assign cur      = (state == PLAY_F1);
   assign start_ok = i_start_wstrobe & ((i_start == 2'd1) | (i_start == 2'd2));

   // A FIFO can be started only with data counted, outside reset, and not being reset now.
   always_comb begin
      busy  = '0;
      avail = '0;
      ld_ok = '0;
      for (int n = 0; n < 2; n++) begin
         busy[n]  = (rst_cnt[n] != '0);
         avail[n] = (cnt[n] != 32'd0) & ~busy[n] & ~rst_req[n];
         ld_ok[n] = ld_stb[n] & ~full[n] & ~busy[n] & ~rst_req[n]
                    & ~((state != IDLE) & (cur == n[0]));
      end
   end

   always_comb begin
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      m_axis_tdata  = '0;
      ren           = '0;
      if (state != IDLE) begin
         m_axis_tvalid = ~empty[cur];
         m_axis_tdata  = rdata[cur];
         m_axis_tlast  = (cnt[cur] == 32'd1);
         ren[cur]      = m_axis_tvalid & m_axis_tready;
      end
   end

   assign last_hs = (|ren) & m_axis_tlast;

   always_comb begin
      state_nxt = state;
      pend_nxt  = pend;
      case (state)
         IDLE: begin
            if (start_ok && !i_hard_stop_wstrobe && avail[i_start[1]])
               state_nxt = state_t'(i_start);
         end
         default: begin
            if (start_ok && (i_start != o_active_fifo))
               pend_nxt = i_start;
            if (last_hs) begin
               pend_nxt  = 2'd0;
               state_nxt = IDLE;
               if ((pend != 2'd0) && avail[pend[1]])
                  state_nxt = state_t'(pend);
            end
            // Stop and reset of the active FIFO override any handoff.
            if (i_hard_stop_wstrobe || rst_req[cur]) begin
               state_nxt = IDLE;
               pend_nxt  = 2'd0;
            end
         end
      endcase
      if (((pend_nxt == 2'd1) && rst_req[0]) || ((pend_nxt == 2'd2) && rst_req[1]))
         pend_nxt = 2'd0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= IDLE;
         pend   <= 2'd0;
         drop_q <= 1'b0;
         wen_q  <= '0;
         for (int n = 0; n < 2; n++) begin
            rst_cnt[n] <= '0;
            cnt[n]     <= '0;
            wdata_q[n] <= '0;
         end
      end else begin
         state  <= state_nxt;
         pend   <= pend_nxt;
         drop_q <= |(ld_stb & ~ld_ok);
         wen_q  <= ld_ok;
         for (int n = 0; n < 2; n++) begin
            // Down-counter spans both the pulse half and the settle half.
            if (rst_req[n])
               rst_cnt[n] <= RC_FULL;
            else if (busy[n])
               rst_cnt[n] <= rst_cnt[n] - RCW'(1);

            if (ld_ok[n])
               wdata_q[n] <= {i_upper32, ld_lo[n]};

            if (rst_req[n])
               cnt[n] <= '0;
            else if (ld_ok[n]) begin
               if (cnt[n] != 32'hFFFF_FFFF)
                  cnt[n] <= cnt[n] + 32'd1;
            end else if (ren[n] && (cnt[n] != 32'd0))
               cnt[n] <= cnt[n] - 32'd1;
         end
      end
   end

   assign o_f0_rst             = (rst_cnt[0] > RC_HALF);
   assign o_f1_rst             = (rst_cnt[1] > RC_HALF);
   assign o_fifo_stat_f0_reset = busy[0];
   assign o_fifo_stat_f1_reset = busy[1];
   assign o_f0_wen             = wen_q[0];
   assign o_f1_wen             = wen_q[1];
   assign o_f0_wdata           = wdata_q[0];
   assign o_f1_wdata           = wdata_q[1];
   assign o_f0_ren             = ren[0];
   assign o_f1_ren             = ren[1];
   assign o_f0_count           = cnt[0];
   assign o_f1_count           = cnt[1];
   assign o_active_fifo        = state;
   assign o_load_drop          = drop_q;

endmodule

// File: tb/tb_sensor_emu_playback_seq.sv
// Directed bench for sensor_emu_playback_seq; two queue-backed FWFT FIFOs stand in for the
// external FIFOs, and all expected values are hand-computed constants.
module tb_sensor_emu_playback_seq;

   logic        clk = 1'b0;
   logic        resetn;
   logic        i_fifo_ctl_f0_reset, i_fifo_ctl_f1_reset, i_fifo_ctl_wstrobe;
   logic [31:0] i_upper32, i_load_f0, i_load_f1;
   logic        i_load_f0_wstrobe, i_load_f1_wstrobe;
   logic [1:0]  i_start;
   logic        i_start_wstrobe, i_hard_stop_wstrobe;
   logic        o_f0_rst, o_f0_wen, o_f0_ren, o_f1_rst, o_f1_wen, o_f1_ren;
   logic [63:0] o_f0_wdata, o_f1_wdata;
   logic        f0_full_force, f1_full_force;
   logic        f0_empty = 1'b1;
   logic        f1_empty = 1'b1;
   logic [63:0] f0_rdata = '0;
   logic [63:0] f1_rdata = '0;
   logic [63:0] m_axis_tdata;
   logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
   logic        o_fifo_stat_f0_reset, o_fifo_stat_f1_reset;
   logic [31:0] o_f0_count, o_f1_count;
   logic [1:0]  o_active_fifo;
   logic        o_load_drop;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   sensor_emu_playback_seq #(.RESET_CYCLES(16)) dut (
      .clk                  (clk),
      .resetn               (resetn),
      .i_fifo_ctl_f0_reset  (i_fifo_ctl_f0_reset),
      .i_fifo_ctl_f1_reset  (i_fifo_ctl_f1_reset),
      .i_fifo_ctl_wstrobe   (i_fifo_ctl_wstrobe),
      .i_upper32            (i_upper32),
      .i_load_f0            (i_load_f0),
      .i_load_f0_wstrobe    (i_load_f0_wstrobe),
      .i_load_f1            (i_load_f1),
      .i_load_f1_wstrobe    (i_load_f1_wstrobe),
      .i_start              (i_start),
      .i_start_wstrobe      (i_start_wstrobe),
      .i_hard_stop_wstrobe  (i_hard_stop_wstrobe),
      .o_f0_rst             (o_f0_rst),
      .o_f0_wen             (o_f0_wen),
      .o_f0_wdata           (o_f0_wdata),
      .i_f0_full            (f0_full_force),
      .i_f0_empty           (f0_empty),
      .o_f0_ren             (o_f0_ren),
      .i_f0_rdata           (f0_rdata),
      .o_f1_rst             (o_f1_rst),
      .o_f1_wen             (o_f1_wen),
      .o_f1_wdata           (o_f1_wdata),
      .i_f1_full            (f1_full_force),
      .i_f1_empty           (f1_empty),
      .o_f1_ren             (o_f1_ren),
      .i_f1_rdata           (f1_rdata),
      .m_axis_tdata         (m_axis_tdata),
      .m_axis_tvalid        (m_axis_tvalid),
      .m_axis_tlast         (m_axis_tlast),
      .m_axis_tready        (m_axis_tready),
      .o_fifo_stat_f0_reset (o_fifo_stat_f0_reset),
      .o_fifo_stat_f1_reset (o_fifo_stat_f1_reset),
      .o_f0_count           (o_f0_count),
      .o_f1_count           (o_f1_count),
      .o_active_fifo        (o_active_fifo),
      .o_load_drop          (o_load_drop)
   );

   // FWFT FIFO stand-ins
   logic [63:0] q0[$];
   logic [63:0] q1[$];

   always @(posedge clk) begin
      if (o_f0_rst) q0.delete();
      else begin
         if (o_f0_ren && q0.size() > 0) void'(q0.pop_front());
         if (o_f0_wen) q0.push_back(o_f0_wdata);
      end
      f0_empty <= (q0.size() == 0);
      f0_rdata <= (q0.size() > 0) ? q0[0] : 64'd0;
   end

   always @(posedge clk) begin
      if (o_f1_rst) q1.delete();
      else begin
         if (o_f1_ren && q1.size() > 0) void'(q1.pop_front());
         if (o_f1_wen) q1.push_back(o_f1_wdata);
      end
      f1_empty <= (q1.size() == 0);
      f1_rdata <= (q1.size() > 0) ? q1[0] : 64'd0;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic load(input int n, input logic [31:0] up, input logic [31:0] lo);
      i_upper32 = up;
      if (n == 0) begin i_load_f0 = lo; i_load_f0_wstrobe = 1'b1; end
      else        begin i_load_f1 = lo; i_load_f1_wstrobe = 1'b1; end
      step();
      i_load_f0_wstrobe = 1'b0;
      i_load_f1_wstrobe = 1'b0;
   endtask

   task automatic start(input logic [1:0] sel);
      i_start = sel;
      i_start_wstrobe = 1'b1;
      step();
      i_start_wstrobe = 1'b0;
   endtask

   task automatic beat(input string tag, input logic [63:0] data, input logic last,
                       input logic [1:0] act);
      check({tag, " tvalid"}, 64'(m_axis_tvalid), 64'd1);
      check({tag, " tdata"},  m_axis_tdata, data);
      check({tag, " tlast"},  64'(m_axis_tlast), 64'(last));
      check({tag, " active"}, 64'(o_active_fifo), 64'(act));
      step();
   endtask

   initial begin
      int rc0, rc1, st0, st1;
      resetn = 1'b0;
      i_fifo_ctl_f0_reset = 0; i_fifo_ctl_f1_reset = 0; i_fifo_ctl_wstrobe = 0;
      i_upper32 = '0; i_load_f0 = '0; i_load_f1 = '0;
      i_load_f0_wstrobe = 0; i_load_f1_wstrobe = 0;
      i_start = '0; i_start_wstrobe = 0; i_hard_stop_wstrobe = 0;
      f0_full_force = 0; f1_full_force = 0; m_axis_tready = 0;
      step(); step();
      check("rst active", 64'(o_active_fifo), 64'd0);
      check("rst tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst f0 count", 64'(o_f0_count), 64'd0);
      check("rst f0 wdata", o_f0_wdata, 64'd0);
      check("rst stat", 64'({o_fifo_stat_f1_reset, o_fifo_stat_f0_reset, o_f1_rst, o_f0_rst}), 64'd0);
      check("rst drop", 64'(o_load_drop), 64'd0);
      resetn = 1'b1;
      step();

      // three words on F0, played back-to-back
      load(0, 32'hA, 32'd1);
      check("ld wen", 64'(o_f0_wen), 64'd1);
      check("ld wdata", o_f0_wdata, 64'h0000000A_00000001);
      load(0, 32'hA, 32'd2);
      load(0, 32'hA, 32'd3);
      check("ld count", 64'(o_f0_count), 64'd3);
      m_axis_tready = 1'b1;
      start(2'd1);
      beat("p1 b1", 64'h0000000A_00000001, 1'b0, 2'd1);
      beat("p1 b2", 64'h0000000A_00000002, 1'b0, 2'd1);
      beat("p1 b3", 64'h0000000A_00000003, 1'b1, 2'd1);
      check("p1 end active", 64'(o_active_fifo), 64'd0);
      check("p1 end tvalid", 64'(m_axis_tvalid), 64'd0);
      check("p1 end count", 64'(o_f0_count), 64'd0);

      // F0 then pending F1, no gap
      load(0, 32'hB, 32'h10);
      load(0, 32'hB, 32'h11);
      load(1, 32'hC, 32'h20);
      start(2'd1);
      check("p2 b1 data", m_axis_tdata, 64'h0000000B_00000010);
      check("p2 b1 last", 64'(m_axis_tlast), 64'd0);
      start(2'd2);
      beat("p2 b2", 64'h0000000B_00000011, 1'b1, 2'd1);
      beat("p2 b3", 64'h0000000C_00000020, 1'b1, 2'd2);
      check("p2 end active", 64'(o_active_fifo), 64'd0);
      check("p2 f1 count", 64'(o_f1_count), 64'd0);

      // backpressure then hard stop after two beats
      m_axis_tready = 1'b0;
      for (int i = 1; i <= 5; i++) load(0, 32'hD, 32'(i));
      start(2'd1);
      check("p3 stall tvalid", 64'(m_axis_tvalid), 64'd1);
      check("p3 stall count", 64'(o_f0_count), 64'd5);
      m_axis_tready = 1'b1; step();
      m_axis_tready = 1'b0; step();
      check("p3 stalled", 64'(o_f0_count), 64'd4);
      check("p3 b2 data", m_axis_tdata, 64'h0000000D_00000002);
      m_axis_tready = 1'b1; step();
      m_axis_tready = 1'b0;
      i_hard_stop_wstrobe = 1'b1; step(); i_hard_stop_wstrobe = 1'b0;
      check("hs active", 64'(o_active_fifo), 64'd0);
      check("hs tvalid", 64'(m_axis_tvalid), 64'd0);
      check("hs count", 64'(o_f0_count), 64'd3);

      // reset sequencing on both FIFOs, with a load attempted while busy
      i_fifo_ctl_f0_reset = 1; i_fifo_ctl_f1_reset = 1; i_fifo_ctl_wstrobe = 1;
      step();
      i_fifo_ctl_wstrobe = 0; i_fifo_ctl_f0_reset = 0; i_fifo_ctl_f1_reset = 0;
      check("rs count", 64'(o_f0_count), 64'd0);
      rc0 = 0; rc1 = 0; st0 = 0; st1 = 0;
      for (int i = 0; i < 40; i++) begin
         rc0 += int'(o_f0_rst); rc1 += int'(o_f1_rst);
         st0 += int'(o_fifo_stat_f0_reset); st1 += int'(o_fifo_stat_f1_reset);
         if (i == 0) begin i_upper32 = 32'h5; i_load_f0 = 32'h5; i_load_f0_wstrobe = 1'b1; end
         if (i == 1) begin
            check("busy drop", 64'(o_load_drop), 64'd1);
            check("busy wen", 64'(o_f0_wen), 64'd0);
         end
         if (i == 2) check("drop pulse", 64'(o_load_drop), 64'd0);
         step();
         i_load_f0_wstrobe = 1'b0;
      end
      check("f0 rst cycles", 64'(rc0), 64'd16);
      check("f1 rst cycles", 64'(rc1), 64'd16);
      check("f0 stat cycles", 64'(st0), 64'd32);
      check("f1 stat cycles", 64'(st1), 64'd32);
      check("rs f0 count", 64'(o_f0_count), 64'd0);

      // ignored starts and full-FIFO drop
      start(2'd1);
      check("empty start", 64'(o_active_fifo), 64'd0);
      load(0, 32'hE, 32'h30);
      check("e count", 64'(o_f0_count), 64'd1);
      start(2'd3);
      check("start3", 64'(o_active_fifo), 64'd0);
      f0_full_force = 1'b1;
      load(0, 32'hE, 32'h31);
      check("full drop", 64'(o_load_drop), 64'd1);
      check("full wen", 64'(o_f0_wen), 64'd0);
      check("full count", 64'(o_f0_count), 64'd1);
      f0_full_force = 1'b0;

      // async reset in the middle of playback
      load(0, 32'hE, 32'h32);
      m_axis_tready = 1'b1;
      start(2'd1);
      check("pre-rst active", 64'(o_active_fifo), 64'd1);
      resetn = 1'b0;
      #1;
      check("arst active", 64'(o_active_fifo), 64'd0);
      check("arst tvalid", 64'({m_axis_tvalid, m_axis_tlast, o_f0_ren}), 64'd0);
      check("arst count", 64'(o_f0_count), 64'd0);
      step();
      resetn = 1'b1;
      step();
      check("post active", 64'(o_active_fifo), 64'd0);
      check("post outs", 64'({m_axis_tvalid, o_f0_wen, o_f0_rst, o_load_drop}), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sensor_emu_playback_seq.md
SENSOR_EMU_PLAYBACK_SEQ -- requirements
Module: sensor_emu_playback_seq

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 16, cycles each FIFO reset pulse is held and then settled.
REQ-002 SHALL have port clk  in  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port resetn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports i_fifo_ctl_f0_reset, i_fifo_ctl_f1_reset, i_fifo_ctl_wstrobe  in  1 each  FIFO reset request bits plus strobe.
REQ-005 SHALL have ports i_upper32  in  32  upper half of each loaded word.
REQ-006 SHALL have ports i_load_fN (N=0,1)  in  32  lower half of word; i_load_fN_wstrobe  in  1  load strobe.
REQ-007 SHALL have ports i_start  in  2  FIFO select (1=F0, 2=F1); i_start_wstrobe  in  1; i_hard_stop_wstrobe  in  1.
REQ-008 SHALL have, per N=0,1: o_fN_rst out 1; o_fN_wen out 1; o_fN_wdata out 64; i_fN_full in 1; i_fN_empty in 1; o_fN_ren out 1; i_fN_rdata in 64 (first-word-fall-through).
REQ-009 SHALL have ports m_axis_tdata out 64, m_axis_tvalid out 1, m_axis_tlast out 1, m_axis_tready in 1.
REQ-010 SHALL have ports o_fifo_stat_f0_reset, o_fifo_stat_f1_reset  out 1 (reset busy); o_f0_count, o_f1_count  out 32; o_active_fifo  out 2 (0 none, 1 F0, 2 F1); o_load_drop  out 1.

Function
REQ-011 Reset sequencing SHALL, on i_fifo_ctl_wstrobe, for each set bit N: assert o_fN_rst for RESET_CYCLES cycles starting next cycle, then hold busy a further RESET_CYCLES cycles; o_fifo_stat_fN_reset high over all 2*RESET_CYCLES cycles.
REQ-012 A reset strobe for a FIFO already busy SHALL restart its sequence from cycle 0.
REQ-013 Reset of FIFO N SHALL clear o_fN_count to 0 next cycle; if N is active or pending, playback SHALL stop (active/pending cleared) same cycle.
REQ-014 Load SHALL, on i_load_fN_wstrobe, drive o_fN_wen=1 and o_fN_wdata={i_upper32,i_load_fN} next cycle for exactly one cycle and increment o_fN_count.
REQ-015 Load SHALL be dropped (no wen, count unchanged, o_load_drop pulses 1 cycle) if FIFO N is full, reset-busy, active, or a reset strobe for N arrives same cycle.
REQ-016 States SHALL be IDLE, PLAY_F0, PLAY_F1; o_active_fifo reflects state (0/1/2).
REQ-017 IDLE SHALL, on i_start_wstrobe with i_start in {1,2}, target FIFO count>0 and not reset-busy, enter PLAY of that FIFO next cycle; otherwise ignore.
REQ-018 In PLAY, start for the other FIFO SHALL be recorded as one-deep pending (later request overwrites); start for the active FIFO or i_start in {0,3} SHALL be ignored.
REQ-019 In PLAY_Fn: m_axis_tvalid = !i_fN_empty; m_axis_tdata = i_fN_rdata; o_fN_ren = tvalid & tready (combinational); each handshake decrements o_fN_count.
REQ-020 m_axis_tlast SHALL be 1 when o_fN_count==1 in PLAY.
REQ-021 On the tlast handshake the next state SHALL be PLAY of the pending FIFO if valid (count>0, not busy), else IDLE; pending cleared. Zero-cycle gap between FIFOs.
REQ-022 i_hard_stop_wstrobe SHALL force IDLE and clear pending next cycle; a handshake occurring that same cycle completes; remaining words stay in FIFO; hard stop beats a same-cycle start.
REQ-023 Outside PLAY, m_axis_tvalid, m_axis_tlast, o_fN_ren SHALL be 0.
REQ-024 Counts SHALL saturate at 0xFFFFFFFF and never underflow below 0.

Reset
REQ-025 While resetn=0: state IDLE, pending none, counts 0, all o_fN_rst/o_fN_wen/o_fN_ren/m_axis_tvalid/m_axis_tlast/o_load_drop/status bits 0, o_fN_wdata 0.
REQ-026 Reset mid-playback or mid-reset-sequence SHALL abort immediately; no further strobes emitted after release until new requests.

Verification
REQ-027 Load F0 three words (upper32=0xA, lower 1,2,3), start=1, tready=1 -> tdata 0xA_00000001..3 on consecutive cycles, tlast on third, o_active_fifo 1->0.
REQ-028 F0 two words, F1 one word, start=1 then start=2 during play -> three back-to-back beats, tlast on beats 2 and 3, active 1->2->0.
REQ-029 Playing F0 (5 words), tready toggles, hard stop after 2 beats -> IDLE next cycle, o_f0_count=3, tvalid 0.
REQ-030 Reset strobe both bits, RESET_CYCLES=16 -> o_fN_rst high 16 cycles, stat high 32 cycles, counts 0; load during busy -> o_load_drop pulse.
REQ-031 Start=1 with o_f0_count=0, and start=3 -> no state change; load F0 with i_f0_full=1 -> dropped.
REQ-032 Assert resetn=0 mid-playback -> all outputs zero asynchronously, state IDLE after release.
